// File: rtl/mode_counter_pkg.sv
// Shared types and elaboration helpers for the mode counter.
// The run-mode encoding here is the one driven on the mode output.
package mode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL    = 2'd0,
        MODE_AUTO_UP   = 2'd1,
        MODE_AUTO_DOWN = 2'd2
    } mode_t;

    // Prescaler register width; never narrower than one bit.
    function automatic int unsigned prescaler_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mode_counter_tick_gen.sv
// Auto-step prescaler: counts 0..TICK_CYCLES-1 and flags the last cycle.
// Disabled means held at zero, so the first tick after enabling is a full period away.
module tick_gen
    import mode_counter_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 125000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = prescaler_width(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!enable || restart || at_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && at_last;

endmodule

// File: rtl/mode_counter.sv
// Up/down LED counter with manual/auto-up/auto-down run modes, parallel load,
// wrap or saturate arithmetic and a one-cycle terminal-count pulse.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned TICK_CYCLES = 125000,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             mode_next,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       mode,
    output logic             tc
);

    mode_t            mode_q;
    mode_t            mode_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

    logic auto_en;
    logic restart;
    logic tick;
    logic manual_step;
    logic auto_step;
    logic step_en;
    logic step_up;
    logic at_bound;

    // Mode FSM; the unused encoding falls back to MANUAL.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_MANUAL:    if (mode_next) mode_d = MODE_AUTO_UP;
            MODE_AUTO_UP:   if (mode_next) mode_d = MODE_AUTO_DOWN;
            MODE_AUTO_DOWN: if (mode_next) mode_d = MODE_MANUAL;
            default:        mode_d = MODE_MANUAL;
        endcase
    end

    assign auto_en = (mode_q == MODE_AUTO_UP) || (mode_q == MODE_AUTO_DOWN);
    assign restart = (mode_d != mode_q) || clr || load;

    tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (auto_en),
        .restart (restart),
        .tick    (tick)
    );

    // inc together with dec is not a step, so a coincident tick still applies.
    assign manual_step = inc ^ dec;
    assign auto_step   = tick && !mode_next && auto_en;
    assign step_en     = manual_step || auto_step;
    assign step_up     = manual_step ? inc : (mode_q == MODE_AUTO_UP);
    assign at_bound    = step_up ? (count_q == {WIDTH{1'b1}}) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (step_en) begin
            tc_d = at_bound;
            if (!(SATURATE && at_bound)) begin
                count_d = step_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_MANUAL;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign mode  = mode_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench: wrap and saturate instances share stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_mode_counter;

    localparam int T   = 8;
    localparam int MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inc, dec, clr, mode_next, load;
    logic [3:0] load_value;
    logic [3:0] count, count_s;
    logic [1:0] mode, mode_s;
    logic       tc, tc_s;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_cnt, m_sat, m_mode, m_ph;
    bit m_tc, m_tcs;

    typedef struct {
        bit i, d, c, mn, ld;
        int lv;
    } stim_t;

    always #5 clk = ~clk;

    mode_counter #(.WIDTH(4), .TICK_CYCLES(T), .SATURATE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr),
        .mode_next(mode_next), .load(load), .load_value(load_value),
        .count(count), .mode(mode), .tc(tc)
    );

    mode_counter #(.WIDTH(4), .TICK_CYCLES(T), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr),
        .mode_next(mode_next), .load(load), .load_value(load_value),
        .count(count_s), .mode(mode_s), .tc(tc_s)
    );

    task automatic model_reset();
        m_cnt = 0; m_sat = 0; m_mode = 0; m_ph = 0; m_tc = 0; m_tcs = 0;
    endtask

    // One clock edge of behaviour, from the rules rather than the RTL structure.
    task automatic model_step(input bit i, input bit d, input bit c, input bit mn,
                              input bit ld, input int lv);
        bit tick;
        int dir;
        int nv;
        tick  = (m_mode != 0) && (m_ph == T - 1);
        dir   = 0;
        m_tc  = 0;
        m_tcs = 0;
        if (c) begin
            m_cnt = 0; m_sat = 0;
        end else if (ld) begin
            m_cnt = lv; m_sat = lv;
        end else begin
            if (i != d) dir = i ? 1 : -1;
            else if (tick && !mn) dir = (m_mode == 1) ? 1 : -1;
            if (dir != 0) begin
                nv = m_cnt + dir;
                if (nv < 0 || nv > MAX) m_tc = 1;
                m_cnt = (nv + MAX + 1) % (MAX + 1);
                nv = m_sat + dir;
                if (nv < 0 || nv > MAX) m_tcs = 1;
                else m_sat = nv;
            end
        end
        if (mn || c || ld || m_mode == 0 || m_ph == T - 1) m_ph = 0;
        else m_ph = m_ph + 1;
        if (mn) m_mode = (m_mode + 1) % 3;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic drive(input bit i, input bit d, input bit c, input bit mn,
                         input bit ld, input int lv);
        inc = i; dec = d; clr = c; mode_next = mn; load = ld; load_value = 4'(lv);
        @(posedge clk);
        model_step(i, d, c, mn, ld, lv);
        @(negedge clk);
        inc = 0; dec = 0; clr = 0; mode_next = 0; load = 0; load_value = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({count, mode, tc, count_s, mode_s, tc_s} !== 14'd0) begin
            errors++;
            $display("FAIL reset_values got %0d/%0d/%0b sat %0d/%0d/%0b want 0/0/0",
                     count, mode, tc, count_s, mode_s, tc_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(k < 3, k == 3, 0, 0, 0, 0);
            checks++;
            if (tc !== 1'b0 || tc_s !== 1'b0) begin
                errors++;
                $display("FAIL reset_seq_tc step %0d got %0b/%0b want 0", k, tc, tc_s);
            end
        end
        checks++;
        if (count !== 4'd2 || count_s !== 4'd2) begin
            errors++;
            $display("FAIL reset_seq_count got %0d/%0d want 2", count, count_s);
        end
        // Enter AUTO_UP, then pull reset mid-prescale away from any edge.
        drive(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (count !== 4'd0 || mode !== 2'd0 || count_s !== 4'd0 || mode_s !== 2'd0) begin
            errors++;
            $display("FAIL reset_async got count %0d mode %0d want 0 0", count, mode);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_saturate();
        stim_t tbl[10];
        tbl[0] = '{0,0,0,0,1,15}; tbl[1] = '{1,0,0,0,0,0};  tbl[2] = '{0,0,0,0,0,0};
        tbl[3] = '{0,1,0,0,0,0};  tbl[4] = '{0,0,0,0,0,0};  tbl[5] = '{0,0,1,0,0,0};
        tbl[6] = '{0,1,0,0,0,0};  tbl[7] = '{0,0,0,0,0,0};  tbl[8] = '{0,0,0,0,1,14};
        tbl[9] = '{1,0,0,0,0,0};
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].i, tbl[k].d, tbl[k].c, tbl[k].mn, tbl[k].ld, tbl[k].lv);
            checks++;
            if ({count, tc} !== {4'(m_cnt), m_tc} || {count_s, tc_s} !== {4'(m_sat), m_tcs}) begin
                errors++;
                $display("FAIL wrap_sat step %0d got %0d/%0b sat %0d/%0b want %0d/%0b sat %0d/%0b",
                         k, count, tc, count_s, tc_s, m_cnt, m_tc, m_sat, m_tcs);
            end
            // Explicit boundary expectations alongside the model.
            if (k == 1) begin
                checks++;
                if ({count, tc, count_s, tc_s} !== {4'd0, 1'b1, 4'd15, 1'b1}) begin
                    errors++;
                    $display("FAIL wrap_up_boundary got %0d/%0b sat %0d/%0b want 0/1 sat 15/1",
                             count, tc, count_s, tc_s);
                end
            end
            if (k == 6) begin
                checks++;
                if ({count, tc, count_s, tc_s} !== {4'd15, 1'b1, 4'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL wrap_down_boundary got %0d/%0b sat %0d/%0b want 15/1 sat 0/1",
                             count, tc, count_s, tc_s);
                end
            end
        end
    endtask

    task automatic test_auto_modes();
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("FAIL auto_mode_up got %0d want 1", mode);
        end
        for (int k = 1; k <= 2 * T; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if ({count, mode, tc} !== {4'(m_cnt), 2'(m_mode), m_tc}) begin
                errors++;
                $display("FAIL auto_up edge %0d got %0d/%0d/%0b want %0d/%0d/%0b",
                         k, count, mode, tc, m_cnt, m_mode, m_tc);
            end
            if (k == T - 1 || k == T || k == 2 * T) begin
                checks++;
                if (count !== ((k < T) ? 4'd0 : (k == T) ? 4'd1 : 4'd2)) begin
                    errors++;
                    $display("FAIL auto_up_timing edge %0d got %0d", k, count);
                end
            end
        end
        drive(0, 0, 0, 1, 0, 0);
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("FAIL auto_mode_down got %0d want 2", mode);
        end
        for (int k = 1; k <= 3 * T; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if ({count, tc, count_s, tc_s} !== {4'(m_cnt), m_tc, 4'(m_sat), m_tcs}) begin
                errors++;
                $display("FAIL auto_down edge %0d got %0d/%0b sat %0d/%0b want %0d/%0b sat %0d/%0b",
                         k, count, tc, count_s, tc_s, m_cnt, m_tc, m_sat, m_tcs);
            end
        end
        drive(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 100; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if ({count, mode, tc} !== {4'(m_cnt), 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL manual_frozen cycle %0d got %0d/%0d/%0b want %0d/0/0",
                         k, count, mode, tc, m_cnt);
            end
        end
    endtask

    task automatic test_priority();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 1, 9);
        checks++;
        if (count !== 4'd0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL prio_clr got %0d/%0b want 0/0", count, tc);
        end
        drive(1, 0, 0, 0, 1, 9);
        checks++;
        if (count !== 4'd9 || tc !== 1'b0) begin
            errors++;
            $display("FAIL prio_load got %0d/%0b want 9/0", count, tc);
        end
        drive(0, 0, 0, 0, 1, 15);
        drive(1, 1, 0, 0, 0, 0);
        checks++;
        if (count !== 4'd15 || tc !== 1'b0 || count_s !== 4'd15 || tc_s !== 1'b0) begin
            errors++;
            $display("FAIL prio_inc_dec got %0d/%0b sat %0d/%0b want 15/0", count, tc, count_s, tc_s);
        end
    endtask

    task automatic test_coincidence();
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        for (int k = 1; k < T; k++) drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (count !== 4'd1 || count !== 4'(m_cnt)) begin
            errors++;
            $display("FAIL coincide_inc got %0d want 1 (model %0d)", count, m_cnt);
        end
        for (int k = 1; k <= T; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if (count !== ((k < T) ? 4'd1 : 4'd2)) begin
                errors++;
                $display("FAIL coincide_next edge %0d got %0d want %0d", k, count, (k < T) ? 1 : 2);
            end
        end
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        bit i, d, c, mn, ld;
        for (int k = 0; k < 600; k++) begin
            i  = ($urandom_range(99) < 20);
            d  = ($urandom_range(99) < 20);
            c  = ($urandom_range(99) < 3);
            ld = ($urandom_range(99) < 5);
            mn = ($urandom_range(99) < 4);
            drive(i, d, c, mn, ld, int'($urandom_range(15)));
            checks++;
            if ({count, mode, tc} !== {4'(m_cnt), 2'(m_mode), m_tc} ||
                {count_s, mode_s, tc_s} !== {4'(m_sat), 2'(m_mode), m_tcs}) begin
                errors++;
                $display("FAIL random cycle %0d got %0d/%0d/%0b sat %0d/%0d/%0b want %0d/%0d/%0b sat %0d/%0b",
                         k, count, mode, tc, count_s, mode_s, tc_s,
                         m_cnt, m_mode, m_tc, m_sat, m_tcs);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        inc = 0; dec = 0; clr = 0; mode_next = 0; load = 0; load_value = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_wrap_saturate();
        test_auto_modes();
        test_priority();
        test_coincidence();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised up/down counter driving the board LEDs from single-cycle button pulses, generalising the 4-bit button counter. Adds configurable width, a programmable auto-step period, three run modes (manual, auto-up, auto-down), parallel load, selectable wrap/saturate arithmetic and a terminal-count pulse. Sits between the button debouncer/edge-detector outputs and the LED or DAC drivers.

## Interface
- `WIDTH`, 4: counter width in bits, 2..32.
- `TICK_CYCLES`, 125000: clk cycles per auto step, ≥2.
- `SATURATE`, 0: 0 means wrap at the boundaries; 1 means clamp at 0 and 2^WIDTH-1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inc`  in  1  one-cycle pulse: step +1.
- `dec`  in  1  one-cycle pulse: step -1.
- `clr`  in  1  one-cycle pulse: count := 0.
- `mode_next`  in  1  one-cycle pulse: advance the run mode.
- `load`  in  1  one-cycle pulse: count := load_value.
- `load_value`  in  WIDTH  parallel load data.
- `count`  out  WIDTH  registered count.
- `mode`  out  2  registered run mode: 0 = MANUAL, 1 = AUTO_UP, 2 = AUTO_DOWN.
- `tc`  out  1  registered one-cycle terminal-count pulse.

## Operation
- Mode FSM: MANUAL -> AUTO_UP -> AUTO_DOWN -> MANUAL on each `mode_next`. Encoding 3 is unreachable and recovers to MANUAL on the next edge.
- Prescaler: counts 0..TICK_CYCLES-1 and emits `tick` when it reaches TICK_CYCLES-1, then returns to 0.
  - Held at 0 in MANUAL.
  - Restarted to 0 on any mode change, `clr` or `load`.
- Update priority per edge, highest first: `clr`, `load`, manual step, auto tick.
- Manual step:
  - `inc` XOR `dec` steps by ±1 in all modes.
  - `inc` and `dec` together: no step and no `tc`.
  - A manual step in an auto mode consumes any coincident `tick`. The prescaler is not restarted.
- Auto tick:
  - AUTO_UP steps +1, AUTO_DOWN steps -1.
  - A `tick` arriving together with `mode_next` is dropped.
- Arithmetic, modulo 2^WIDTH:
  - Wrap mode: max+1 -> 0 and 0-1 -> max.
  - Saturate mode: the step is blocked at the boundary and the count holds.
- `tc` asserts for one cycle, coincident with the new `count`, when a step (manual or auto):
  - wraps in either direction, or
  - is blocked by saturation.
  - `clr` and `load` never assert `tc`.
- `mode_next` takes effect together with any same-cycle count update; both apply.

## Timing
- Reset values: `count` = 0, `mode` = MANUAL, prescaler = 0, `tc` = 0. Reset applies immediately on `rst_n` falling, including mid-prescale; counting resumes in MANUAL.
- All outputs are registered. An input pulse sampled at edge N is visible on the outputs after edge N.
- First auto step lands TICK_CYCLES edges after the `mode_next` edge, then every TICK_CYCLES edges.
- Inputs are synchronous to `clk` and already debounced. Each pulse counts once per high cycle, so a level held for k cycles steps k times.

## Structure
- `mode_counter_pkg` holds:
  - `mode_t` enum {MODE_MANUAL, MODE_AUTO_UP, MODE_AUTO_DOWN}.
  - A `clog2`-based prescaler-width localparam helper.
- Sub-module `tick_gen`:
  - Parameter `TICK_CYCLES`.
  - Ports `clk`, `rst_n`, `enable`, `restart`, `tick`.
- The top level holds the mode FSM, the priority mux and the wrap/saturate logic.

## Test plan
All scenarios use WIDTH=4 and TICK_CYCLES=8 unless noted.
- Reset, then 3 `inc` pulses and 1 `dec` pulse -> `count` = 2 and `tc` never asserted. Assert `rst_n` low mid-sequence -> `count` = 0 and `mode` = 0 immediately.
- Wrap: `load` 15, then `inc` -> `count` = 0 with a 1-cycle `tc`. Then `dec` -> `count` = 15 with a 1-cycle `tc`.
- SATURATE=1: `load` 15, then `inc` -> `count` stays 15 with `tc`. `clr`, then `dec` -> `count` stays 0 with `tc`.
- Auto modes:
  - 1 `mode_next` -> `mode` = 1; `count` goes 0->1 exactly 8 edges later and 1->2 after 16 edges.
  - 2nd `mode_next` -> `mode` = 2; `count` decrements every 8 edges.
  - 3rd `mode_next` -> `mode` = 0; `count` frozen for 100 cycles.
- Priority: `clr`+`load`(9)+`inc` in the same cycle -> `count` = 0. `load`(9)+`inc` -> `count` = 9. `inc`+`dec` -> unchanged, no `tc`.
- Coincidence: in AUTO_UP, drive `inc` on the tick edge -> `count` increments by exactly 1. The next auto step follows 8 edges later.
